mult_share_ctrl: RTL

//  Shares one iterative booth_multiplier among NREQ requesters. Round-robin grant, valid/ready

---
 rtl/mult_share_ctrl_pkg.sv | 15 +
 rtl/mult_share_ctrl_if.sv | 29 ++
 rtl/mult_share_ctrl_rr_pick.sv | 33 +++
 rtl/mult_share_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and default sizing for the multiplier-sharing controller.
// State encoding is fixed so the encoding can be read directly from the state register.
package mult_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_LATENCY = 8;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request, shared-multiplier and response signals of the multiplier-sharing controller.
// slave is the controller's view; master is the requester/consumer/multiplier environment.
interface mult_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_p;
    logic              rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult_share_ctrl_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; purely combinational.
// Returns the one-hot grant, its index, and whether any request was present.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    logic           found;
    logic [IDW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one iterative multiplier among NREQ requesters: round-robin grant in IDLE,
// operands held LATENCY cycles in RUN, product held in DONE until the consumer accepts it.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_share_ctrl_if.slave   bus,
    output logic               busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(LATENCY) + 1;

    state_e         state_q,  state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [W-1:0]   op_a_q,   op_a_d;
    logic [W-1:0]   op_b_q,   op_b_d;
    logic [2*W-1:0] rsp_p_q,  rsp_p_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            any_vld;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_vld)
    );

    // Picker only grants a requester that is valid, so any grant in IDLE is a handshake.
    assign bus.req_ready = (state_q == ST_IDLE) ? gnt : '0;
    assign bus.mul_a     = op_a_q;
    assign bus.mul_b     = op_b_q;
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rsp_p_d  = rsp_p_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    op_a_d   = bus.req_a[int'(gnt_idx)*W +: W];
                    op_b_d   = bus.req_b[int'(gnt_idx)*W +: W];
                    rsp_id_d = gnt_idx;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    rsp_p_d = bus.mul_p;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
        end
    end

endmodule
